// File: rtl/dec5t32_pkg.sv
// Shared widths for the 5-to-32 decoder slice.
// Split into four 8-output groups selected by the top two index bits.
package dec5t32_pkg;

    localparam int SEL_W = 5;
    localparam int OUT_W = 32;
    localparam int GRP_N = 4;
    localparam int GRP_W = 8;
    localparam int LO_W  = 3;

endpackage

// File: rtl/dec5t32_dec3t8.sv
// 3-to-8 one-hot decoder with active-high enable.
// Enable is ANDed into every output so an unknown select decodes to 0.
module dec3t8
    import dec5t32_pkg::*;
(
    input  logic [LO_W-1:0]  sel,
    input  logic             en,
    output logic [GRP_W-1:0] y
);

    // One output per select value, each gated by the enable
    always_comb begin
        y = '0;
        for (int k = 0; k < GRP_W; k++) begin
            y[k] = en & (sel == LO_W'(k));
        end
    end

endmodule

// File: rtl/dec5t32.sv
// 5-to-32 one-hot decoder: 2-to-4 predecoder feeding four 3-to-8 decoders.
// OUT_REG=1 adds a one-cycle output register with async active-high clear.
module dec5t32
    import dec5t32_pkg::*;
#(
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] I,
    input  logic             En,
    output logic [OUT_W-1:0] Y
);

    logic [GRP_N-1:0] grp_en;
    logic [OUT_W-1:0] d;

    // Predecode the group index; En gating keeps X on I from leaking out
    always_comb begin
        grp_en = '0;
        for (int g = 0; g < GRP_N; g++) begin
            grp_en[g] = En & (I[SEL_W-1:LO_W] == 2'(g));
        end
    end

    for (genvar g = 0; g < GRP_N; g++) begin : g_grp
        dec3t8 u_dec (
            .sel (I[LO_W-1:0]),
            .en  (grp_en[g]),
            .y   (d[g*GRP_W +: GRP_W])
        );
    end

    if (OUT_REG) begin : g_reg
        logic [OUT_W-1:0] y_q;

        // Register the decode; reset clears without waiting for clk
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y_q <= '0;
            end else begin
                y_q <= d;
            end
        end

        assign Y = y_q;
    end else begin : g_comb
        // clk/rst have no role in the combinational build
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign Y = d;
    end

endmodule

// File: tb/tb_dec5t32.sv
// Directed bench for dec5t32: combinational and registered builds.
// Expected values are hand-computed constants or En ? 1<<I : 0.
module tb_dec5t32;

    logic        clk;
    logic        rst;
    logic [4:0]  I;
    logic        En;
    logic [31:0] yc;
    logic [31:0] yr;

    int checks = 0;
    int errors = 0;

    dec5t32 #(.OUT_REG(1'b0)) u_dut_c (
        .clk (clk),
        .rst (rst),
        .I   (I),
        .En  (En),
        .Y   (yc)
    );

    dec5t32 #(.OUT_REG(1'b1)) u_dut_r (
        .clk (clk),
        .rst (rst),
        .I   (I),
        .En  (En),
        .Y   (yr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10] = '{
        '{5'd0,  32'h0000_0001},
        '{5'd1,  32'h0000_0002},
        '{5'd7,  32'h0000_0080},
        '{5'd8,  32'h0000_0100},
        '{5'd10, 32'h0000_0400},
        '{5'd16, 32'h0001_0000},
        '{5'd23, 32'h0080_0000},
        '{5'd24, 32'h0100_0000},
        '{5'd31, 32'h8000_0000},
        '{5'd5,  32'h0000_0020}
    };

    initial begin
        rst = 1'b1;
        En  = 1'b0;
        I   = 5'd0;
        #1;
        chk("reset_reg", yr, 32'h0);
        chk("dis_i0", yc, 32'h0);

        for (int i = 0; i < 32; i++) begin
            I = 5'(i);
            #1;
            chk($sformatf("dis_sweep%0d", i), yc, 32'h0);
        end

        I = 5'bxxxxx;
        #1;
        chk("dis_x", yc, 32'h0);

        En = 1'b1;
        for (int i = 0; i < 32; i++) begin
            I = 5'(i);
            #10;
            chk($sformatf("sweep%0d", i), yc, 32'h1 << i);
        end

        foreach (vecs[k]) begin
            I = vecs[k].idx;
            #1;
            chk($sformatf("vec%0d", vecs[k].idx), yc, vecs[k].exp);
            chk($sformatf("hot%0d", vecs[k].idx),
                32'($countones(yc)), 32'd1);
        end

        I  = 5'd31;
        En = 1'b1;
        #1;
        chk("drop_on", yc, 32'h8000_0000);
        En = 1'b0;
        #1;
        chk("drop_off", yc, 32'h0);
        chk("reg_held", yr, 32'h0);

        @(negedge clk);
        En  = 1'b1;
        I   = 5'd5;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reg_i5", yr, 32'h20);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reg_async", yr, 32'h0);
        chk("comb_rst", yc, 32'h20);
        @(posedge clk);
        #1;
        chk("reg_rst_hold", yr, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reg_rel", yr, 32'h0);
        @(posedge clk);
        #1;
        chk("reg_first", yr, 32'h20);

        @(negedge clk);
        I = 5'd6;
        #1;
        chk("reg_lat", yr, 32'h20);
        @(posedge clk);
        #1;
        chk("reg_i6", yr, 32'h40);

        @(negedge clk);
        En = 1'b0;
        @(posedge clk);
        #1;
        chk("reg_en0", yr, 32'h0);
        @(negedge clk);
        En = 1'b1;
        @(posedge clk);
        #1;
        chk("reg_en1", yr, 32'h40);

        @(negedge clk);
        I = 5'd31;
        @(posedge clk);
        #1;
        chk("reg_i31", yr, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec5t32.md
Name: dec5t32

Overview:
- 5-to-32 one-hot decoder with active-high enable, used for register-file write-select and address decode in the CPU datapath.
- The default configuration is purely combinational; the Y path is independent of clk and rst.
- An optional output register gives a one-cycle-latency variant for timing-critical uses.
- Built structurally from a 2-to-4 predecoder driving four 3-to-8 decoders.

Parameters:
- OUT_REG, default 0: 0 = Y combinational from I/En; 1 = Y registered on rising clk.

Ports:
- clk  input  1  system clock; used only when OUT_REG=1.
- rst  input  1  asynchronous, active-high reset; clears the output register when OUT_REG=1.
- I    input  5  binary select index, 0..31.
- En   input  1  active-high decode enable.
- Y    output 32  one-hot decode result; bit k corresponds to I==k.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Decode function: D = En ? (32'b1 << I) : 32'h0000_0000.
- When En=1, exactly one bit of D is high, at position I.
- When En=0, all 32 bits of D are low, regardless of I.
- OUT_REG=0:
  - Y = D, zero-cycle latency, no state.
  - clk and rst have no effect on Y.
  - Y settles within the same delta as any I/En change.
- OUT_REG=1:
  - Y is a 32-bit register loaded with D on each rising clk (latency 1 cycle).
  - rst=1 clears Y to 32'h0 immediately (asynchronous), independent of clk.
  - Y holds 0 while rst is high.
  - First load is at the first rising clk after rst deasserts.
- Structure:
  - Predecoder on I[4:3], gated by En, produces group enables G[3:0].
  - Sub-decoder g decodes I[2:0] onto Y[8g+7 : 8g] when G[g]=1, else drives 0.
- Boundaries:
  - I=0 gives Y=32'h0000_0001.
  - I=31 gives Y=32'h8000_0000.
  - Toggling En with I held changes Y between 0 and the single decoded bit, with no glitch to any other bit in the registered variant.
- X/Z on I with En=0 yields Y=0.
- No handshake and no internal state other than the optional output register.

Decomposition:
- No shared package types are required.
- Optionally place the localparam constants SEL_W=5 and OUT_W=32 in the common CPU constants package.
- One natural sub-module, dec3t8: 3-bit input, 1-bit enable, 8-bit one-hot output, same En-gated semantics.
- dec5t32 instantiates four dec3t8 copies plus an inline 2-to-4 enable predecoder.

Test Plan:
- Disabled: En=0, I=5'b00000 -> Y=32'h0000_0000; then sweep I 0..31 with En=0 -> Y stays 0 throughout.
- Full sweep: En=1, I stepped 0..31 every 10 ns -> Y=32'h1<<I after each step, e.g. I=1 -> 32'h2, I=10 -> 32'h400, I=16 -> 32'h0001_0000, I=31 -> 32'h8000_0000.
- Group boundaries: I=7 -> 32'h80, I=8 -> 32'h100, I=23 -> 32'h0080_0000, I=24 -> 32'h0100_0000; confirm one-hot, i.e. $countones(Y)==1.
- Enable drop: En=1, I=5'b11111 -> Y=32'h8000_0000; then En=0 -> Y=0 within the same timestep (OUT_REG=0).
- Registered mode (OUT_REG=1):
  - Assert rst mid-stream with En=1, I=5 -> Y=0 immediately, without a clock edge.
  - Release rst -> Y=32'h20 one clk after release.
  - Change I to 6 -> Y=32'h40 one cycle later.
- Self-check: every sweep step compares Y against the reference model (En ? 1<<I : 0), with a zero-mismatch pass criterion.
